// File: rtl/calc_unit.sv
// Self-sequencing calculator datapath: command latch, register file, ALU with
// iterative multiply, and a result/flag register behind a go/done handshake.
module calc_unit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             ld,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [AW-1:0]    raa,
    input  logic [AW-1:0]    rab,
    input  logic [AW-1:0]    wa,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_EXEC, S_WB} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_SHL, OP_MUL, OP_PASS
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   in1_q, in1_d, in2_q, in2_d;
    logic [AW-1:0]      raa_q, raa_d, rab_q, rab_d, wa_q, wa_d;
    logic [WIDTH-1:0]   rf_q [DEPTH];
    logic [WIDTH-1:0]   rf_d [DEPTH];
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               rcarry_q, rcarry_d, rovf_q, rovf_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     add_ext, sub_ext;
    logic [2*WIDTH-1:0] partial, prod_nxt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;

    always_comb begin
        add_ext  = {1'b0, a_q} + {1'b0, b_q};
        sub_ext  = {1'b0, a_q} - {1'b0, b_q};
        // One shift-add step per EXEC cycle, multiplier bit selected by cnt_q
        partial  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        prod_nxt = prod_q + partial;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SHL:  alu_res = (b_q >= WIDTH'(WIDTH)) ? '0 : (a_q << b_q);
            OP_MUL: begin
                alu_res = prod_nxt[WIDTH-1:0];
                alu_c   = |prod_nxt[2*WIDTH-1:WIDTH];
            end
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        raa_d    = raa_q;
        rab_d    = rab_q;
        wa_d     = wa_q;
        rf_d     = rf_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rcarry_d = rcarry_q;
        rovf_d   = rovf_q;
        out_d    = out_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    op_d    = op_t'(op);
                    in1_d   = in1;
                    in2_d   = in2;
                    raa_d   = raa;
                    rab_d   = rab;
                    wa_d    = wa;
                    state_d = ld ? S_LOAD : S_READ;
                end
            end
            S_LOAD: begin
                rf_d[raa_q] = in1_q;
                rf_d[rab_q] = in2_q;
                state_d     = S_READ;
            end
            S_READ: begin
                a_d     = rf_q[raa_q];
                b_d     = rf_q[rab_q];
                prod_d  = '0;
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                prod_d = prod_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (op_q != OP_MUL || cnt_q == CW'(WIDTH - 1)) begin
                    res_d    = alu_res;
                    rcarry_d = alu_c;
                    rovf_d   = alu_v;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                rf_d[wa_q] = res_q;
                out_d      = res_q;
                zero_d     = (res_q == '0);
                carry_d    = rcarry_q;
                ovf_d      = rovf_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            in1_q    <= '0;
            in2_q    <= '0;
            raa_q    <= '0;
            rab_q    <= '0;
            wa_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            rcarry_q <= 1'b0;
            rovf_q   <= 1'b0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            raa_q    <= raa_d;
            rab_q    <= rab_d;
            wa_q     <= wa_d;
            rf_q     <= rf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            rcarry_q <= rcarry_d;
            rovf_q   <= rovf_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign out   = out_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_calc_unit.sv
// Scoreboard bench for calc_unit: commands push expected results, a monitor
// pops and checks them whenever done pulses.
module tb_calc_unit;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, go, ld;
    logic [2:0]   op;
    logic [W-1:0] in1, in2;
    logic [1:0]   raa, rab, wa;
    logic [W-1:0] out;
    logic         busy, done, zero, carry, ovf;

    calc_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .go(go), .ld(ld), .op(op),
        .in1(in1), .in2(in2), .raa(raa), .rab(rab), .wa(wa),
        .out(out), .busy(busy), .done(done), .zero(zero),
        .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int out; int zero; int carry; int ovf; int lat; int go_cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done_queue_size", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("out",     int'(out),   mon_e.out);
                chk("zero",    int'(zero),  mon_e.zero);
                chk("carry",   int'(carry), mon_e.carry);
                chk("ovf",     int'(ovf),   mon_e.ovf);
                chk("latency", cyc - mon_e.go_cyc, mon_e.lat);
            end
        end
    end

    task automatic start_cmd(input bit l, input int o, input int a, input int b,
                             input int ra, input int rb, input int w, input bit push,
                             input int eo, input int ez, input int ec, input int ev,
                             input int el);
        exp_t e;
        @(negedge clk);
        ld  = l;
        op  = o[2:0];
        in1 = a[W-1:0];
        in2 = b[W-1:0];
        raa = ra[1:0];
        rab = rb[1:0];
        wa  = w[1:0];
        go  = 1'b1;
        if (push) begin
            e.out = eo; e.zero = ez; e.carry = ec; e.ovf = ev; e.lat = el;
            e.go_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", int'(done), 1);
    endtask

    task automatic run(input bit l, input int o, input int a, input int b,
                       input int ra, input int rb, input int w,
                       input int eo, input int ez, input int ec, input int ev,
                       input int el);
        start_cmd(l, o, a, b, ra, rb, w, 1'b1, eo, ez, ec, ev, el);
        wait_done();
    endtask

    task automatic model(input int o, input int a, input int b,
                         output int r, output int c, output int v);
        int s;
        c = 0;
        v = 0;
        case (o)
            0: begin
                s = a + b;
                r = s % 16;
                c = (s > 15) ? 1 : 0;
                v = (((a >> 3) == (b >> 3)) && ((r >> 3) != (a >> 3))) ? 1 : 0;
            end
            1: begin
                r = (a - b + 16) % 16;
                c = (a < b) ? 1 : 0;
                v = (((a >> 3) != (b >> 3)) && ((r >> 3) != (a >> 3))) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a ^ b;
            default: r = a | b;
        endcase
    endtask

    initial begin
        int r, c, v;
        rst = 1'b1; go = 1'b0; ld = 1'b0; op = '0;
        in1 = '0; in2 = '0; raa = '0; rab = '0; wa = '0;
        repeat (2) @(negedge clk);
        chk("reset_out",   int'(out),   0);
        chk("reset_busy",  int'(busy),  0);
        chk("reset_done",  int'(done),  0);
        chk("reset_zero",  int'(zero),  0);
        chk("reset_carry", int'(carry), 0);
        chk("reset_ovf",   int'(ovf),   0);
        rst = 1'b0;

        // PASS load then readback without load
        run(1, 7, 5, 0, 1, 0, 3, 5, 0, 0, 0, 4);
        run(0, 7, 9, 9, 1, 0, 2, 5, 0, 0, 0, 3);

        // Arithmetic spot checks
        run(1, 0, 7, 9, 0, 1, 2,  0, 1, 1, 0, 4);
        run(1, 0, 7, 1, 0, 1, 2,  8, 0, 0, 1, 4);
        run(1, 1, 3, 5, 0, 1, 2, 14, 0, 1, 0, 4);
        run(1, 6, 7, 3, 0, 1, 2,  5, 0, 1, 0, 7);
        run(1, 6, 3, 5, 0, 1, 2, 15, 0, 0, 0, 7);
        run(1, 5, 3, 2, 0, 1, 2, 12, 0, 0, 0, 4);
        run(1, 5, 3, 4, 0, 1, 2,  0, 1, 0, 0, 4);

        // raa == rab: in2 wins, both operands 6
        run(1, 0, 1, 6, 2, 2, 3, 12, 0, 0, 1, 4);
        // wa == raa overwrites operand register, read back with PASS
        run(1, 0, 4, 5, 3, 0, 3,  9, 0, 0, 1, 4);
        run(0, 7, 0, 0, 3, 0, 1,  9, 0, 0, 0, 3);

        for (int o = 0; o < 5; o++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    model(o, a, b, r, c, v);
                    run(1, o, a, b, 0, 1, 2, r, (r == 0) ? 1 : 0, c, v, 4);
                end

        // go pulses and input changes while busy must not disturb the MUL
        start_cmd(1, 6, 3, 5, 0, 1, 2, 1'b1, 15, 0, 0, 0, 7);
        @(negedge clk);
        chk("busy_mid_cmd", int'(busy), 1);
        go = 1'b1; ld = 1'b0; op = 3'b000; in1 = 4'd9; in2 = 4'd9; raa = 2'd3; wa = 2'd0;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1; in1 = 4'd1;
        @(negedge clk);
        go = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        run(0, 7, 0, 0, 2, 0, 3, 15, 0, 0, 0, 3);

        // Reset during MUL EXEC aborts with no writeback
        start_cmd(1, 6, 7, 3, 1, 2, 3, 1'b0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",  int'(busy),  0);
        chk("abort_done",  int'(done),  0);
        chk("abort_out",   int'(out),   0);
        chk("abort_zero",  int'(zero),  0);
        chk("abort_carry", int'(carry), 0);
        chk("abort_ovf",   int'(ovf),   0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run(0, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3);
        run(0, 7, 0, 0, 2, 0, 0, 0, 1, 0, 0, 3);
        run(1, 6, 7, 3, 0, 1, 2, 5, 0, 1, 0, 7);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/calc_unit.md
Name: calc_unit

Overview:
Parametrised, self-sequencing calculator datapath. It combines operand input, a DEPTH-entry register file, an ALU and an output register behind a go/done handshake. An internal FSM generates the mux-select, write-enable and read-enable steps, so the host no longer toggles each control line cycle by cycle. It adds OR, shift-left, iterative multiply, status flags and configurable width/depth.

Parameters:
WIDTH, 4, datapath and register width in bits (>=2)
DEPTH, 4, number of registers in the file (power of 2, >=2); AW = clog2(DEPTH) is derived internally

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
go  in  1  start request, sampled only in IDLE
ld  in  1  1: write in1/in2 into reg[raa]/reg[rab] before operating; 0: operate on existing contents
op  in  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SHL, 110 MUL, 111 PASS (A)
in1  in  WIDTH  operand A input
in2  in  WIDTH  operand B input
raa  in  AW  register address for operand A
rab  in  AW  register address for operand B
wa  in  AW  result destination register
out  out  WIDTH  result register
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is written
zero  out  1  result == 0
carry  out  1  ADD carry-out / SUB borrow / MUL high-half nonzero
ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (async): FSM->IDLE; all registers, out, flags, done and busy go to 0; the latched command is discarded.
- Command latch: on the go edge in IDLE, ld, op, in1, in2, raa, rab and wa are captured. Later input changes do not affect the running command.
- FSM states: IDLE -> (go) LOAD if ld else READ; LOAD -> READ; READ -> EXEC; EXEC -> WB (single-cycle ops) or stays for MUL until the count is exhausted; WB -> IDLE.
- LOAD: reg[raa]<=in1 and reg[rab]<=in2 in the same edge. If raa==rab, in2 wins.
- READ: A<=reg[raa], B<=reg[rab]. Values written in LOAD are visible here.
- EXEC: single-cycle ops compute in one cycle.
- MUL: shift-add over WIDTH cycles. The 2*WIDTH product is formed, out = low WIDTH bits, carry = |high half.
- SHL: result = A << B. If B >= WIDTH, result = 0. carry = 0.
- WB: reg[wa]<=result, out<=result, flags updated, done=1 for exactly this cycle. wa may equal raa/rab (overwrite permitted).
- Latency from the go edge to the done-high cycle: ld=1 single-cycle op = 4 cycles; ld=0 = 3 cycles; MUL adds WIDTH-1 cycles.
- Arithmetic wraps modulo 2^WIDTH.
- ADD: carry = bit WIDTH of A+B; ovf = operands share a sign and the result sign differs.
- SUB: result = A-B; carry = (A<B unsigned); ovf = operand signs differ and the result sign differs from A.
- Flags for logical ops/SHL/PASS: carry = ovf = 0; zero is computed for every op.
- Holding: out and flags hold their values until the next WB.
- go while busy is ignored and is not queued. A go held high across the return to IDLE starts a new command on the next edge.
- Reset mid-operation: immediate abort, no writeback, done stays 0.

Test Plan:
- Reset, then PASS with ld=1, raa=1, in1=5 -> out=5, zero=0, done pulse exactly 4 cycles after go; reg1=5 confirmed by a later ld=0 PASS (done after 3 cycles).
- Exhaustive sweep, WIDTH=4: in1,in2 in 0..15 for ADD/SUB/AND/XOR/OR -> out matches (in1 op in2) mod 16. Spot checks: 7+9 -> out=0, zero=1, carry=1, ovf=0; 7+1 -> 8, ovf=1; 3-5 -> 14, carry=1, ovf=0.
- MUL 7*3 -> out=5, carry=1; 3*5 -> out=15, carry=0; done 4+3=7 cycles after go (ld=1). SHL 3<<2 -> 12; 3<<4 -> 0.
- Address corners: ld=1 with raa=rab=2, in1=1, in2=6, ADD -> out=12 (both operands 6); wa=raa -> result overwrites the operand register, read back with PASS.
- go pulsed during busy and inputs changed mid-command -> ignored, result unchanged, single done pulse.
- Assert rst during EXEC of MUL -> busy=0, done never pulses, out/flags/registers all 0. The next command runs normally.
